jt51_pg_regs: RTL and testbench

- Register-side feeder for the phase generator, writing to its staged inputs.
- Captures CPU writes to the YM2151 frequency, detune, multiplier and key-on registers.
- Drives the 32-slot time-multiplexed parameter stream at the exact pipeline stage each input is consumed: kc/kf/pms/dt2 at I, dt1 at II, pg_rst at III, mul at VI.
- Also generates the slot counter and the zero marker.

---
 rtl/jt51_pg_regs_pkg.sv | 54 +++++
 rtl/jt51_pg_regs_dly.sv | 32 +++
 rtl/jt51_pg_regs.sv | 165 ++++++++++++++++
 tb/tb_jt51_pg_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_pg_regs_pkg.sv
// Shared constants and helpers for the phase-generator register feeder:
// register address map, slot groups and key-on bit mapping.
package jt51_pg_regs_pkg;

    localparam logic [7:0] KC_BASE     = 8'h28;
    localparam logic [7:0] KF_BASE     = 8'h30;
    localparam logic [7:0] PMS_BASE    = 8'h38;
    localparam logic [7:0] DT1MUL_BASE = 8'h40;
    localparam logic [7:0] DT2_BASE    = 8'hC0;

    // Operator groups occupy slot[4:3]
    localparam logic [1:0] GRP_M1 = 2'd0;
    localparam logic [1:0] GRP_M2 = 2'd1;
    localparam logic [1:0] GRP_C1 = 2'd2;
    localparam logic [1:0] GRP_C2 = 2'd3;

    typedef enum logic [2:0] {
        REG_NONE   = 3'd0,
        REG_KC     = 3'd1,
        REG_KF     = 3'd2,
        REG_PMS    = 3'd3,
        REG_DT1MUL = 3'd4,
        REG_DT2    = 3'd5,
        REG_KON    = 3'd6
    } reg_sel_e;

    // Classify a register address; anything unknown is accepted and ignored.
    function automatic reg_sel_e decode_addr(input logic [7:0] addr,
                                             input logic [7:0] kon_addr);
        reg_sel_e sel;
        if (addr == kon_addr) begin
            sel = REG_KON;
        end else if ((addr & 8'hF8) == KC_BASE) begin
            sel = REG_KC;
        end else if ((addr & 8'hF8) == KF_BASE) begin
            sel = REG_KF;
        end else if ((addr & 8'hF8) == PMS_BASE) begin
            sel = REG_PMS;
        end else if ((addr & 8'hE0) == DT1MUL_BASE) begin
            sel = REG_DT1MUL;
        end else if ((addr & 8'hE0) == DT2_BASE) begin
            sel = REG_DT2;
        end else begin
            sel = REG_NONE;
        end
        return sel;
    endfunction

    // Key-on data[6:3] is ordered M1,C1,M2,C2; result is indexed by group.
    function automatic logic [3:0] kon_to_groups(input logic [3:0] kon_bits);
        return {kon_bits[3], kon_bits[1], kon_bits[2], kon_bits[0]};
    endfunction

endpackage

// File: rtl/jt51_pg_regs_dly.sv
// Clock-enabled shift-register delay line used to stage per-slot
// parameters to the pipeline step where they are consumed.
module jt51_pg_regs_dly #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_r [STAGES];

    // Shift one stage per cen; reset empties the whole line
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_r[i] <= '0;
            end
        end else if (cen) begin
            pipe_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign q = pipe_r[STAGES-1];

endmodule

// File: rtl/jt51_pg_regs.sv
// YM2151 phase-generator register feeder: captures CPU writes and streams
// the 32-slot parameters, each at the pipeline stage that consumes it.
module jt51_pg_regs
    import jt51_pg_regs_pkg::*;
#(
    parameter logic [7:0] KON_ADDR = 8'h08,
    parameter int         MUL_DLY  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       zero,
    output logic [4:0] slot_I,
    output logic [6:0] kc_I,
    output logic [5:0] kf_I,
    output logic [2:0] pms_I,
    output logic [1:0] dt2_I,
    output logic [2:0] dt1_II,
    output logic [3:0] mul_VI,
    output logic       pg_rst_III
);

    // Per-channel and per-slot parameter storage
    logic [6:0] kc_r       [8];
    logic [5:0] kf_r       [8];
    logic [2:0] pms_r      [8];
    logic [2:0] dt1_r      [32];
    logic [3:0] mul_r      [32];
    logic [1:0] dt2_r      [32];
    logic       kon_r      [32];
    logic       kon_seen_r [32];

    logic       wr_ready_r;
    logic [7:0] hold_addr_r;
    logic [7:0] hold_data_r;
    logic [4:0] cnt_r;
    logic [2:0] dt1_i_r;
    logic [3:0] mul_i_r;
    logic       rise_i_r;

    reg_sel_e   sel_s;
    logic       accept_s;
    logic       commit_s;
    logic [4:0] cnt_nxt_s;
    logic [2:0] kon_ch_s;
    logic [3:0] kon_grp_s;
    logic       rise_s;

    // Decode of the held write and the slot about to enter stage I
    always_comb begin
        sel_s     = decode_addr(hold_addr_r, KON_ADDR);
        accept_s  = wr_en & wr_ready_r;
        commit_s  = ~wr_ready_r & cen;
        cnt_nxt_s = cnt_r + 5'd1;
        kon_ch_s  = hold_data_r[2:0];
        kon_grp_s = kon_to_groups(hold_data_r[6:3]);
        rise_s    = kon_r[cnt_nxt_s] & ~kon_seen_r[cnt_nxt_s];
    end

    // Holding register and commit into parameter storage
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ready_r  <= 1'b1;
            hold_addr_r <= 8'h00;
            hold_data_r <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                kc_r[i]  <= 7'd0;
                kf_r[i]  <= 6'd0;
                pms_r[i] <= 3'd0;
            end
            for (int i = 0; i < 32; i++) begin
                dt1_r[i] <= 3'd0;
                mul_r[i] <= 4'd0;
                dt2_r[i] <= 2'd0;
                kon_r[i] <= 1'b0;
            end
        end else if (accept_s) begin
            hold_addr_r <= wr_addr;
            hold_data_r <= wr_data;
            wr_ready_r  <= 1'b0;
        end else if (commit_s) begin
            wr_ready_r <= 1'b1;
            case (sel_s)
                REG_KC:     kc_r[hold_addr_r[2:0]]  <= hold_data_r[6:0];
                REG_KF:     kf_r[hold_addr_r[2:0]]  <= hold_data_r[7:2];
                REG_PMS:    pms_r[hold_addr_r[2:0]] <= hold_data_r[6:4];
                REG_DT1MUL: begin
                    dt1_r[hold_addr_r[4:0]] <= hold_data_r[6:4];
                    mul_r[hold_addr_r[4:0]] <= hold_data_r[3:0];
                end
                REG_DT2:    dt2_r[hold_addr_r[4:0]] <= hold_data_r[7:6];
                REG_KON: begin
                    kon_r[{GRP_M1, kon_ch_s}] <= kon_grp_s[0];
                    kon_r[{GRP_M2, kon_ch_s}] <= kon_grp_s[1];
                    kon_r[{GRP_C1, kon_ch_s}] <= kon_grp_s[2];
                    kon_r[{GRP_C2, kon_ch_s}] <= kon_grp_s[3];
                end
                default: begin
                end
            endcase
        end
    end

    // Slot counter and stage-I read; storage reads see pre-commit values
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= 5'd0;
            slot_I   <= 5'd0;
            zero     <= 1'b1;
            kc_I     <= 7'd0;
            kf_I     <= 6'd0;
            pms_I    <= 3'd0;
            dt2_I    <= 2'd0;
            dt1_i_r  <= 3'd0;
            mul_i_r  <= 4'd0;
            rise_i_r <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                kon_seen_r[i] <= 1'b0;
            end
        end else if (cen) begin
            cnt_r                 <= cnt_nxt_s;
            slot_I                <= cnt_nxt_s;
            zero                  <= (cnt_nxt_s == 5'd0);
            kc_I                  <= kc_r[cnt_nxt_s[2:0]];
            kf_I                  <= kf_r[cnt_nxt_s[2:0]];
            pms_I                 <= pms_r[cnt_nxt_s[2:0]];
            dt2_I                 <= dt2_r[cnt_nxt_s];
            dt1_i_r               <= dt1_r[cnt_nxt_s];
            mul_i_r               <= mul_r[cnt_nxt_s];
            rise_i_r              <= rise_s;
            kon_seen_r[cnt_nxt_s] <= kon_r[cnt_nxt_s];
        end
    end

    assign wr_ready = wr_ready_r;

    jt51_pg_regs_dly #(.WIDTH(3), .STAGES(1)) u_dt1_dly (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .d   (dt1_i_r),
        .q   (dt1_II)
    );

    jt51_pg_regs_dly #(.WIDTH(4), .STAGES(MUL_DLY)) u_mul_dly (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .d   (mul_i_r),
        .q   (mul_VI)
    );

    jt51_pg_regs_dly #(.WIDTH(1), .STAGES(2)) u_pg_rst_dly (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .d   (rise_i_r),
        .q   (pg_rst_III)
    );

endmodule

// File: tb/tb_jt51_pg_regs.sv
// Scoreboard bench for jt51_pg_regs: stimulus pushes hand-derived expected
// snapshots tagged with their target clock; a monitor pops and compares.
module tb_jt51_pg_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       zero;
    logic [4:0] slot_I;
    logic [6:0] kc_I;
    logic [5:0] kf_I;
    logic [2:0] pms_I;
    logic [1:0] dt2_I;
    logic [2:0] dt1_II;
    logic [3:0] mul_VI;
    logic       pg_rst_III;

    jt51_pg_regs #(.KON_ADDR(8'h08), .MUL_DLY(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .zero       (zero),
        .slot_I     (slot_I),
        .kc_I       (kc_I),
        .kf_I       (kf_I),
        .pms_I      (pms_I),
        .dt2_I      (dt2_I),
        .dt1_II     (dt1_II),
        .mul_VI     (mul_VI),
        .pg_rst_III (pg_rst_III)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tgt;
        bit         full;
        logic       ready;
        logic [4:0] slot;
        logic       zero;
        logic [6:0] kc;
        logic [5:0] kf;
        logic [2:0] pms;
        logic [1:0] dt2;
        logic [2:0] dt1;
        logic [3:0] mul;
        logic       pgr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   exp_slot;
    bit   exp_ready;

    // Reference tables, filled with hand-decoded values after each write
    logic [6:0] m_kc  [8];
    logic [5:0] m_kf  [8];
    logic [2:0] m_pms [8];
    logic [1:0] m_dt2 [32];
    logic [2:0] m_dt1 [32];
    logic [3:0] m_mul [32];
    bit         pulse_at [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req, input logic [4:0] s);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (slot %0d): got %0h, expected %0h", name, s, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
            e = exp_q.pop_front();
            check("wr_ready", 32'(wr_ready), 32'(e.ready), e.slot);
            if (e.full) begin
                check("slot_I",     32'(slot_I),     32'(e.slot), e.slot);
                check("zero",       32'(zero),       32'(e.zero), e.slot);
                check("kc_I",       32'(kc_I),       32'(e.kc),   e.slot);
                check("kf_I",       32'(kf_I),       32'(e.kf),   e.slot);
                check("pms_I",      32'(pms_I),      32'(e.pms),  e.slot);
                check("dt2_I",      32'(dt2_I),      32'(e.dt2),  e.slot);
                check("dt1_II",     32'(dt1_II),     32'(e.dt1),  e.slot);
                check("mul_VI",     32'(mul_VI),     32'(e.mul),  e.slot);
                check("pg_rst_III", 32'(pg_rst_III), 32'(e.pgr),  e.slot);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_kc[i] = 7'd0; m_kf[i] = 6'd0; m_pms[i] = 3'd0;
        end
        for (int i = 0; i < 32; i++) begin
            m_dt2[i] = 2'd0; m_dt1[i] = 3'd0; m_mul[i] = 4'd0; pulse_at[i] = 1'b0;
        end
    endtask

    task automatic push_exp(input bit full);
        exp_t e;
        int   s;
        s      = exp_slot;
        e.tgt  = cyc + 1;
        e.full = full;
        e.ready = exp_ready;
        e.slot = 5'(s);
        e.zero = (s == 0);
        e.kc   = m_kc[s % 8];
        e.kf   = m_kf[s % 8];
        e.pms  = m_pms[s % 8];
        e.dt2  = m_dt2[s];
        e.dt1  = m_dt1[(s + 31) % 32];
        e.mul  = m_mul[(s + 27) % 32];
        e.pgr  = pulse_at[s];
        exp_q.push_back(e);
    endtask

    // One clock: drive cen, optionally expect a snapshot right after the edge
    task automatic step(input bit c, input bit chk, input bit full);
        cen = c;
        if (rst) exp_slot = 0;
        else if (c) exp_slot = (exp_slot + 1) % 32;
        if (chk) push_exp(full);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input bit chk);
        for (int i = 0; i < n; i++) step(1'b1, chk, 1'b1);
    endtask

    task automatic wait_slot(input int s);
        while (exp_slot != s) step(1'b1, 1'b0, 1'b1);
    endtask

    // Accept with cen low, commit on the following cen edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        exp_ready = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        wr_en = 1'b0;
        exp_ready = 1'b1;
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        exp_slot = 0; exp_ready = 1'b1;
        clear_model();

        // Reset while cen toggles, then a full wrap of the slot counter
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        run(33, 1'b1);

        // Channel 0 frequency, slot 5 DT1/MUL, slot 9 DT2
        wr(8'h28, 8'h4A); m_kc[0]  = 7'h4A;
        wr(8'h30, 8'hFC); m_kf[0]  = 6'h3F;
        wr(8'h38, 8'h50); m_pms[0] = 3'd5;
        wr(8'h45, 8'h37); m_dt1[5] = 3'd3; m_mul[5] = 4'd7;
        wr(8'hC9, 8'hC0); m_dt2[9] = 2'd3;
        run(40, 1'b0);
        run(32, 1'b1);

        // Key-on channel 2, M1 and C1: pulses for slots 2 and 18
        wait_slot(20);
        wr(8'h08, 8'h1A);
        pulse_at[4] = 1'b1; pulse_at[20] = 1'b1;
        run(40, 1'b1);
        pulse_at[4] = 1'b0; pulse_at[20] = 1'b0;

        // Same key-on again: already seen, no pulse
        wait_slot(20);
        wr(8'h08, 8'h1A);
        run(40, 1'b1);

        // Off then on before the slot is visited: no pulse
        wait_slot(20);
        wr(8'h08, 8'h02);
        wr(8'h08, 8'h1A);
        run(40, 1'b1);

        // Off with a visit in between, then on: pulses return
        wait_slot(20);
        wr(8'h08, 8'h02);
        run(40, 1'b1);
        wait_slot(20);
        wr(8'h08, 8'h1A);
        pulse_at[4] = 1'b1; pulse_at[20] = 1'b1;
        run(40, 1'b1);
        pulse_at[4] = 1'b0; pulse_at[20] = 1'b0;

        // Back-to-back: second write blocked while cen stays low
        wr_en = 1'b1; wr_addr = 8'h2B; wr_data = 8'h22;
        exp_ready = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        wr_addr = 8'h2C; wr_data = 8'h33;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        exp_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        exp_ready = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        wr_en = 1'b0;
        exp_ready = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        m_kc[3] = 7'h22; m_kc[4] = 7'h33;
        run(40, 1'b0);
        run(32, 1'b1);

        // Reset with a write pending: the write is lost
        wr_en = 1'b1; wr_addr = 8'h29; wr_data = 8'h11;
        exp_ready = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        wr_en = 1'b0;
        rst = 1'b1;
        clear_model();
        exp_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        run(33, 1'b1);

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
